sent_rx_dispatch: RTL

Frame dispatcher between the UDP receive stream and the per-channel SENT transmitters. It parses each `rx_axis_udp` frame header, then does one of three things: routes parameter frames to the addressed channel's configuration port, routes data-frame payload words into the addressed channel's FIFO, or discards the frame. The stream has no backpressure, so the block gates each frame at header time on the channel's `sent_ready` / `sent_fifo_pfull` status and drops frames it cannot deliver, counting every drop.

---
 rtl/sent_rx_dispatch.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sent_rx_dispatch.sv
// sent_rx_dispatch: parses frames from the UDP receive stream and routes them
// to the per-channel SENT transmitters. Parameter frames become a one-cycle
// cfg_valid pulse with the cfg_* bus, data-frame payload goes to the channel
// FIFO, and anything undeliverable is dropped and counted.
// Optional build macro SENT_CFG_CHECK_EN enables range checks on parameter frames.
module sent_rx_dispatch #(
  parameter int          SENT_NUM      = 2,
  parameter logic [15:0] ID_SENT_PARAM = 16'd2,
  parameter logic [15:0] ID_SENT_DATA  = 16'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         rx_axis_udp_tdata,
  input  logic                rx_axis_udp_tvalid,
  input  logic                rx_axis_udp_tlast,
  input  logic [SENT_NUM-1:0] sent_ready,
  input  logic [SENT_NUM-1:0] sent_fifo_pfull,
  output logic [SENT_NUM-1:0] cfg_valid,
  output logic [7:0]          cfg_ctick_len,
  output logic [7:0]          cfg_ltick_len,
  output logic [1:0]          cfg_pause_mode,
  output logic [15:0]         cfg_pause_len,
  output logic                cfg_crc_mode,
  output logic [SENT_NUM-1:0] fifo_wr_en,
  output logic [31:0]         fifo_wr_data,
  output logic [15:0]         drop_cnt,
  output logic [2:0]          drop_code
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_DATA, S_DISCARD} state_t;

  localparam logic [8:0] NUM_CH = 9'(SENT_NUM);

  state_t              state_q, state_d;
  logic [7:0]          ch_q, ch_d;
  logic [7:0]          ctick_q, ctick_d;
  logic [7:0]          ltick_q, ltick_d;
  logic [1:0]          pmode_q, pmode_d;
  logic [7:0]          plen_hi_q, plen_hi_d;

  logic [SENT_NUM-1:0] cfg_valid_q, fifo_wr_en_q, ch_sel;
  logic [7:0]          cfg_ctick_q, cfg_ltick_q;
  logic [1:0]          cfg_pmode_q;
  logic [15:0]         cfg_plen_q, drop_cnt_q;
  logic                cfg_crc_q;
  logic [31:0]         fifo_wr_data_q;
  logic [2:0]          drop_code_q;

  logic [255:0]        ready_ext, pfull_ext;
  logic [15:0]         hdr_id, pause_len_w;
  logic [7:0]          hdr_ch;
  logic                cfg_pass, wr_go, cfg_go, drop_go;
  logic [2:0]          drop_code_d;

  assign hdr_id      = rx_axis_udp_tdata[31:16];
  assign hdr_ch      = rx_axis_udp_tdata[15:8];
  assign ready_ext   = 256'(sent_ready);
  assign pfull_ext   = 256'(sent_fifo_pfull);
  assign pause_len_w = {plen_hi_q, rx_axis_udp_tdata[31:24]};

`ifdef SENT_CFG_CHECK_EN
  function automatic logic cfg_legal(input logic [7:0] ct, input logic [7:0] lt,
                                     input logic [1:0] pm, input logic [15:0] pl);
    logic ok;
    ok = 1'b1;
    if (ct < 8'd3 || ct > 8'd90) ok = 1'b0;
    if (lt < 8'd4) ok = 1'b0;
    if (pm == 2'd3) ok = 1'b0;
    if (pm != 2'd0 && (pl < 16'd12 || pl > 16'd768)) ok = 1'b0;
    return ok;
  endfunction
  assign cfg_pass = cfg_legal(ctick_q, ltick_q, pmode_q, pause_len_w);
`else
  assign cfg_pass = 1'b1;
`endif

  // Decode the latched channel into a one-hot strobe pattern
  always_comb begin
    for (int i = 0; i < SENT_NUM; i++) ch_sel[i] = (ch_q == 8'(i));
  end

  // Frame parser: next state, header gating decisions and drop reasons
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    ctick_d     = ctick_q;
    ltick_d     = ltick_q;
    pmode_d     = pmode_q;
    plen_hi_d   = plen_hi_q;
    wr_go       = 1'b0;
    cfg_go      = 1'b0;
    drop_go     = 1'b0;
    drop_code_d = 3'd0;
    if (rx_axis_udp_tvalid) begin
      case (state_q)
        S_IDLE: begin
          ch_d = hdr_ch;
          if (rx_axis_udp_tlast) begin
            drop_go = 1'b1; drop_code_d = 3'd1;
          end else if ({1'b0, hdr_ch} >= NUM_CH) begin
            drop_go = 1'b1; drop_code_d = 3'd2; state_d = S_DISCARD;
          end else if (hdr_id == ID_SENT_PARAM) begin
            if (!ready_ext[hdr_ch]) begin
              drop_go = 1'b1; drop_code_d = 3'd3; state_d = S_DISCARD;
            end else begin
              state_d = S_P1;
            end
          end else if (hdr_id == ID_SENT_DATA) begin
            if (pfull_ext[hdr_ch]) begin
              drop_go = 1'b1; drop_code_d = 3'd4; state_d = S_DISCARD;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            drop_go = 1'b1; drop_code_d = 3'd5; state_d = S_DISCARD;
          end
        end
        S_P1: begin
          ctick_d   = rx_axis_udp_tdata[31:24];
          ltick_d   = rx_axis_udp_tdata[23:16];
          pmode_d   = rx_axis_udp_tdata[9:8];
          plen_hi_d = rx_axis_udp_tdata[7:0];
          if (rx_axis_udp_tlast) begin
            drop_go = 1'b1; drop_code_d = 3'd6; state_d = S_IDLE;
          end else begin
            state_d = S_P2;
          end
        end
        S_P2: begin
          if (!rx_axis_udp_tlast) begin
            drop_go = 1'b1; drop_code_d = 3'd6; state_d = S_DISCARD;
          end else begin
            state_d = S_IDLE;
            if (cfg_pass) cfg_go = 1'b1;
            else begin
              drop_go = 1'b1; drop_code_d = 3'd7;
            end
          end
        end
        S_DATA: begin
          wr_go = 1'b1;
          if (rx_axis_udp_tlast) state_d = S_IDLE;
        end
        S_DISCARD: begin
          if (rx_axis_udp_tlast) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Parser state and registered outputs; all outputs clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cfg_valid_q    <= '0;
      fifo_wr_en_q   <= '0;
      fifo_wr_data_q <= '0;
      cfg_ctick_q    <= '0;
      cfg_ltick_q    <= '0;
      cfg_pmode_q    <= '0;
      cfg_plen_q     <= '0;
      cfg_crc_q      <= 1'b0;
      drop_cnt_q     <= '0;
      drop_code_q    <= '0;
    end else begin
      state_q      <= state_d;
      fifo_wr_en_q <= wr_go ? ch_sel : '0;
      cfg_valid_q  <= cfg_go ? ch_sel : '0;
      if (wr_go) fifo_wr_data_q <= rx_axis_udp_tdata;
      if (cfg_go) begin
        cfg_ctick_q <= ctick_q;
        cfg_ltick_q <= ltick_q;
        cfg_pmode_q <= pmode_q;
        cfg_plen_q  <= pause_len_w;
        cfg_crc_q   <= rx_axis_udp_tdata[16];
      end
      if (drop_go) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        drop_code_q <= drop_code_d;
      end
    end
  end

  // Frame context captured from the header and first parameter word
  always_ff @(posedge clk) begin
    ch_q      <= ch_d;
    ctick_q   <= ctick_d;
    ltick_q   <= ltick_d;
    pmode_q   <= pmode_d;
    plen_hi_q <= plen_hi_d;
  end

  assign cfg_valid      = cfg_valid_q;
  assign cfg_ctick_len  = cfg_ctick_q;
  assign cfg_ltick_len  = cfg_ltick_q;
  assign cfg_pause_mode = cfg_pmode_q;
  assign cfg_pause_len  = cfg_plen_q;
  assign cfg_crc_mode   = cfg_crc_q;
  assign fifo_wr_en     = fifo_wr_en_q;
  assign fifo_wr_data   = fifo_wr_data_q;
  assign drop_cnt       = drop_cnt_q;
  assign drop_code      = drop_code_q;

endmodule
